// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU arbiter: width defaults, FSM state codes and ALU opcodes.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;

endpackage

// File: rtl/alu_arb_grant.sv
// Two-way round-robin grant: picks at most one requester while the arbiter is idle.
module alu_arb_grant (
  input  logic       idle,
  input  logic       prio,
  input  logic [1:0] valid,
  output logic [1:0] ready
);

  // On contention the requester matching prio wins; a lone requester always wins.
  always_comb begin
    ready = 2'b00;
    if (idle) begin
      case (valid)
        2'b01:   ready = 2'b01;
        2'b10:   ready = 2'b10;
        2'b11:   ready = prio ? 2'b10 : 2'b01;
        default: ready = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// Optional macro ALU_ARB_ZERO_FLAG_EN adds rsp_zero, the registered (alu_out == 0) flag.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req0_in2,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [DATA_W-1:0] req1_in2,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              busy,
`ifdef ALU_ARB_ZERO_FLAG_EN
  output logic              rsp_zero,
`endif
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_out
);

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT);

  logic [1:0] state;
  logic       prio;
  logic       id;
  logic [3:0] cnt;
  logic [1:0] ready_vec;
  logic       idle;
  logic       sel;
  logic       accept;

  // Ready is also held low while reset is asserted.
  assign idle = (state == ST_IDLE) && rst_n;

  alu_arb_grant u_grant (
    .idle  (idle),
    .prio  (prio),
    .valid ({req1_valid, req0_valid}),
    .ready (ready_vec)
  );

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign sel        = ready_vec[1];
  assign accept     = |ready_vec;
  assign rsp_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      prio       <= 1'b0;
      id         <= 1'b0;
      cnt        <= 4'd0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_opcode <= '0;
`ifdef ALU_ARB_ZERO_FLAG_EN
      rsp_zero   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_in1    <= sel ? req1_in1 : req0_in1;
            alu_in2    <= sel ? req1_in2 : req0_in2;
            alu_opcode <= sel ? req1_op  : req0_op;
            id         <= sel;
            cnt        <= CNT_INIT;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          cnt <= cnt - 4'd1;
          // The ALU has settled on the held operands for ALU_LAT cycles by now.
          if (cnt == 4'd1) begin
            rsp_data <= alu_out;
            rsp_id   <= id;
`ifdef ALU_ARB_ZERO_FLAG_EN
            rsp_zero <= (alu_out == '0);
`endif
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            prio  <= ~rsp_id;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 8-bit combinational ALU between two requesters, req0 and req1.
- Each operation is accepted over a valid/ready request handshake and returned over a valid/ready response handshake.
- The block drives the ALU operand and opcode inputs from latched registers and captures the ALU result after a fixed settle time.
- Position: between the instruction sequencer and datapath clients on one side and the ALU on the other.

Parameters:
- DATA_W, 8, operand/result width.
- OP_W, 3, opcode width.
- ALU_LAT, 1, cycles the latched operands are held on the ALU before the result is captured; legal range 1-15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_in1, req0_in2 / req1_in1, req1_in2  in  DATA_W  operands.
- req0_op / req1_op  in  OP_W  opcode.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  DATA_W  result.
- rsp_id  out  1  requester served (0/1).
- busy  out  1  state != IDLE.
- alu_in1, alu_in2  out  DATA_W  to ALU.
- alu_opcode  out  OP_W  to ALU.
- alu_out  in  DATA_W  from ALU.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values:
  - state=IDLE, prio=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - alu_in1=0, alu_in2=0, alu_opcode=0.
  - req*_ready=0.
- Reset mid-operation discards the in-flight op; rsp_valid is low from the next edge.
- ALU opcode map driven through unchanged: 000 add, 001 sub, 010 and, 011 xor, others pass in1. Result is mod 2^DATA_W; the arbiter never checks opcodes.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req*_ready is combinational and asserted only in IDLE, to at most one requester.
  - Only one valid: that requester gets ready.
  - Both valid: the requester equal to prio gets ready.
  - On valid&&ready: latch in1, in2, op and id; load cnt=ALU_LAT; go to EXEC.
- EXEC:
  - alu_in1/alu_in2/alu_opcode = latched values; these registers change only on accept.
  - cnt decrements each cycle.
  - In the cycle cnt==1: rsp_data<=alu_out, rsp_id<=id, go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data and rsp_id are stable until rsp_valid&&rsp_ready.
  - On handshake: prio<=~rsp_id, go to IDLE.
  - rsp_ready held high in advance completes on the first RESP cycle.
- Latency: accept at edge T; rsp_valid high from edge T+ALU_LAT.
- Throughput: minimum ALU_LAT+2 cycles per op.
- A lone requester is served repeatedly with no starvation penalty.
- Requester valid may drop before ready without effect. Request inputs are ignored outside IDLE.
- No ready/valid combinational loop: ready depends only on state, prio and valid.

Optional Feature:
- Macro: ALU_ARB_ZERO_FLAG_EN.
- Defined: extra output rsp_zero (1 bit), registered with rsp_data, equal to (alu_out==0) at capture; reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package alu_arb_pkg: state enum (IDLE, EXEC, RESP), opcode constants (OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_XOR=3'b011), DATA_W/OP_W defaults.
- One sub-module, alu_arb_grant: the 2-way round-robin grant logic (valids, prio, idle -> ready vector).
- FSM, counter and datapath registers stay in the top module.

Test Plan:
- Reset: rst_n=0 for 2 cycles with both valids high -> all outputs 0, no ready asserted.
- Single op: req0 {in1=0x05, in2=0x03, op=000}, rsp_ready=1, ALU_LAT=1 -> rsp_valid one cycle after accept, rsp_data=0x08, rsp_id=0.
- Contention: both valid at reset exit (req0 sub 0x10-0x01, req1 xor 0xF0^0x0F) -> req0 served first (0x0F, id 0), then req1 (0xFF, id 1). Repeat with both valid -> order alternates.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data/rsp_id stable, both readys low, busy=1; after rsp_ready=1 -> IDLE next cycle.
- Wrap and latency: ALU_LAT=3, add 0xFF+0x02 -> rsp_data=0x01 at accept+3; alu_in1/alu_in2 held for 3 cycles.
- Mid-op reset: rst_n low during EXEC -> rsp_valid never rises, next request served normally. With ALU_ARB_ZERO_FLAG_EN, sub 0x22-0x22 -> rsp_zero=1.
